// File: rtl/lsu_lsq_deq_ctrl.sv
// In-order LSQ dequeue/commit controller.
// Watches the LSQ head entry, retires loads and excepting entries directly,
// and runs ROB-grant -> D-cache request/response before retiring stores.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  synchronous pipeline flush
//   lsq_*_vec_i / *_flat_i per-entry status published by the LSQ entries
//   rob_commit_*           ROB store commit grant
//   st_req_* / st_resp_*   D-cache store port handshake
//   lsq_entry_invld_vec_o  one-hot dequeue strobe (combinational, fire cycle)
//   lsu_rob_cmpl_*_o       registered one-cycle completion report to the ROB
//   lsq_head_ptr_o         current head pointer
module lsu_lsq_deq_ctrl #(
  parameter int unsigned LSQ_DEPTH                 = 8,
  parameter int unsigned LSQ_PTR_WIDTH             = 3,
  parameter int unsigned LSQ_ENTRY_ROB_INDEX_WIDTH = 4,
  parameter int unsigned EXCEPTION_CAUSE_WIDTH     = 4
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                flush,
  input  logic [LSQ_DEPTH-1:0]                                lsq_vld_vec_i,
  input  logic [LSQ_DEPTH-1:0]                                lsq_ls_vec_i,
  input  logic [LSQ_DEPTH-1:0]                                lsq_succ_vec_i,
  input  logic [LSQ_DEPTH-1:0]                                lsq_exception_vld_vec_i,
  input  logic [LSQ_DEPTH*LSQ_ENTRY_ROB_INDEX_WIDTH-1:0]      lsq_rob_index_flat_i,
  input  logic [LSQ_DEPTH*EXCEPTION_CAUSE_WIDTH-1:0]          lsq_ecause_flat_i,
  input  logic                                                rob_commit_vld_i,
  input  logic [LSQ_ENTRY_ROB_INDEX_WIDTH-1:0]                rob_commit_rob_index_i,
  output logic                                                st_req_vld_o,
  input  logic                                                st_req_rdy_i,
  output logic [LSQ_PTR_WIDTH-1:0]                            st_req_lsq_index_o,
  input  logic                                                st_resp_vld_i,
  output logic [LSQ_DEPTH-1:0]                                lsq_entry_invld_vec_o,
  output logic                                                lsu_rob_cmpl_vld_o,
  output logic [LSQ_ENTRY_ROB_INDEX_WIDTH-1:0]                lsu_rob_cmpl_rob_index_o,
  output logic                                                lsu_rob_cmpl_exception_vld_o,
  output logic [EXCEPTION_CAUSE_WIDTH-1:0]                    lsu_rob_cmpl_ecause_o,
  output logic [LSQ_PTR_WIDTH-1:0]                            lsq_head_ptr_o
);

  localparam int unsigned RW = LSQ_ENTRY_ROB_INDEX_WIDTH;
  localparam int unsigned EW = EXCEPTION_CAUSE_WIDTH;
  localparam int unsigned PW = LSQ_PTR_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic            st_req_vld_q, st_req_vld_d;
  logic [PW-1:0]   st_req_idx_q, st_req_idx_d;
  logic            cmpl_vld_q, cmpl_vld_d;
  logic [RW-1:0]   cmpl_rob_q, cmpl_rob_d;
  logic            cmpl_exc_q, cmpl_exc_d;
  logic [EW-1:0]   cmpl_ecause_q, cmpl_ecause_d;

  logic            retire_c;
  logic            retire_exc_c;

  // Unpack the flat per-entry fields so the head can select them directly
  logic [RW-1:0] rob_idx_arr [LSQ_DEPTH];
  logic [EW-1:0] ecause_arr  [LSQ_DEPTH];

  for (genvar i = 0; i < LSQ_DEPTH; i++) begin : g_unpack
    assign rob_idx_arr[i] = lsq_rob_index_flat_i[i*RW +: RW];
    assign ecause_arr[i]  = lsq_ecause_flat_i[i*EW +: EW];
  end

  logic          head_vld_c, head_ls_c, head_succ_c, head_exc_c;
  logic [RW-1:0] head_rob_c;
  logic [EW-1:0] head_ecause_c;

  // Head entry status
  always_comb begin
    head_vld_c    = lsq_vld_vec_i[head_q];
    head_ls_c     = lsq_ls_vec_i[head_q];
    head_succ_c   = lsq_succ_vec_i[head_q];
    head_exc_c    = lsq_exception_vld_vec_i[head_q];
    head_rob_c    = rob_idx_arr[head_q];
    head_ecause_c = ecause_arr[head_q];
  end

  // Next-state, head and retire decision
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    retire_c     = 1'b0;
    retire_exc_c = 1'b0;

    if (flush && (state_q != DRAIN)) begin
      // An accepted store must still see its response, so ST_WAIT drains
      head_d  = '0;
      state_d = (state_q == ST_WAIT) ? DRAIN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (head_vld_c) begin
            if (head_exc_c) begin
              retire_c     = 1'b1;
              retire_exc_c = 1'b1;
            end else if (!head_ls_c && head_succ_c) begin
              retire_c = 1'b1;
            end else if (head_ls_c && head_succ_c && rob_commit_vld_i &&
                         (rob_commit_rob_index_i == head_rob_c)) begin
              state_d = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (st_req_rdy_i) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (st_resp_vld_i) begin
            retire_c = 1'b1;
            state_d  = IDLE;
          end
        end
        DRAIN: begin
          if (st_resp_vld_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (retire_c) head_d = head_q + PW'(1);
    end
  end

  // Registered output next values
  always_comb begin
    st_req_vld_d  = (state_d == ST_REQ);
    st_req_idx_d  = st_req_vld_d ? head_d : '0;
    cmpl_vld_d    = retire_c;
    cmpl_rob_d    = retire_c ? head_rob_c : '0;
    cmpl_exc_d    = retire_exc_c;
    cmpl_ecause_d = retire_exc_c ? head_ecause_c : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      head_q        <= '0;
      st_req_vld_q  <= 1'b0;
      st_req_idx_q  <= '0;
      cmpl_vld_q    <= 1'b0;
      cmpl_rob_q    <= '0;
      cmpl_exc_q    <= 1'b0;
      cmpl_ecause_q <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      st_req_vld_q  <= st_req_vld_d;
      st_req_idx_q  <= st_req_idx_d;
      cmpl_vld_q    <= cmpl_vld_d;
      cmpl_rob_q    <= cmpl_rob_d;
      cmpl_exc_q    <= cmpl_exc_d;
      cmpl_ecause_q <= cmpl_ecause_d;
    end
  end

  // Dequeue strobe is valid in the fire cycle itself
  assign lsq_entry_invld_vec_o        = retire_c ? (LSQ_DEPTH'(1) << head_q) : '0;
  assign st_req_vld_o                 = st_req_vld_q;
  assign st_req_lsq_index_o           = st_req_idx_q;
  assign lsu_rob_cmpl_vld_o           = cmpl_vld_q;
  assign lsu_rob_cmpl_rob_index_o     = cmpl_rob_q;
  assign lsu_rob_cmpl_exception_vld_o = cmpl_exc_q;
  assign lsu_rob_cmpl_ecause_o        = cmpl_ecause_q;
  assign lsq_head_ptr_o               = head_q;

endmodule

// File: tb/tb_lsu_lsq_deq_ctrl.sv
// Self-checking bench for lsu_lsq_deq_ctrl: expected ROB completions are
// queued when a retire is provoked and popped when the pulse appears.
module tb_lsu_lsq_deq_ctrl;

  localparam int unsigned D  = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned RW = 4;
  localparam int unsigned EW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            flush;
  logic [D-1:0]    vld, ls, succ, exc;
  logic [RW-1:0]   rob [D];
  logic [EW-1:0]   ec  [D];
  logic [D*RW-1:0] rob_flat;
  logic [D*EW-1:0] ec_flat;
  logic            commit_vld;
  logic [RW-1:0]   commit_idx;
  logic            st_req_vld;
  logic            st_req_rdy;
  logic [PW-1:0]   st_req_idx;
  logic            st_resp;
  logic [D-1:0]    invld;
  logic            cmpl_vld;
  logic [RW-1:0]   cmpl_rob;
  logic            cmpl_exc;
  logic [EW-1:0]   cmpl_ec;
  logic [PW-1:0]   head;

  always_comb begin
    rob_flat = '0;
    ec_flat  = '0;
    for (int i = 0; i < D; i++) begin
      rob_flat[i*RW +: RW] = rob[i];
      ec_flat[i*EW +: EW]  = ec[i];
    end
  end

  lsu_lsq_deq_ctrl #(
    .LSQ_DEPTH(D), .LSQ_PTR_WIDTH(PW),
    .LSQ_ENTRY_ROB_INDEX_WIDTH(RW), .EXCEPTION_CAUSE_WIDTH(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lsq_vld_vec_i(vld), .lsq_ls_vec_i(ls), .lsq_succ_vec_i(succ),
    .lsq_exception_vld_vec_i(exc),
    .lsq_rob_index_flat_i(rob_flat), .lsq_ecause_flat_i(ec_flat),
    .rob_commit_vld_i(commit_vld), .rob_commit_rob_index_i(commit_idx),
    .st_req_vld_o(st_req_vld), .st_req_rdy_i(st_req_rdy),
    .st_req_lsq_index_o(st_req_idx), .st_resp_vld_i(st_resp),
    .lsq_entry_invld_vec_o(invld),
    .lsu_rob_cmpl_vld_o(cmpl_vld), .lsu_rob_cmpl_rob_index_o(cmpl_rob),
    .lsu_rob_cmpl_exception_vld_o(cmpl_exc), .lsu_rob_cmpl_ecause_o(cmpl_ec),
    .lsq_head_ptr_o(head)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;
  // {rob index, exception, ecause}
  logic [RW+EW:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (cmpl_vld) begin
        if (sb.size() == 0) begin
          chk("unexpected_cmpl", 32'(cmpl_rob), 32'hFFFF_FFFF);
        end else begin
          logic [RW+EW:0] e;
          e = sb.pop_front();
          chk("cmpl_rob_index", 32'(cmpl_rob), 32'(e[RW+EW:EW+1]));
          chk("cmpl_exc_vld",   32'(cmpl_exc), 32'(e[EW]));
          if (e[EW]) chk("cmpl_ecause", 32'(cmpl_ec), 32'(e[EW-1:0]));
        end
      end else begin
        chk("cmpl_idle_zero", 32'({cmpl_rob, cmpl_exc, cmpl_ec}), 32'h0);
      end
    end
  end

  task automatic do_load(input int h, input logic [RW-1:0] r);
    step();
    vld[h] = 1'b1; ls[h] = 1'b0; succ[h] = 1'b1; exc[h] = 1'b0; rob[h] = r;
    @(negedge clk);
    chk("load_head", 32'(head), 32'(h));
    chk("load_invld", 32'(invld), 32'(1) << h);
    sb.push_back({r, 1'b0, 4'h0});
    step();
    vld[h] = 1'b0;
    @(negedge clk);
    chk("load_head_adv", 32'(head), 32'((h + 1) % D));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    vld = '0; ls = '0; succ = '0; exc = '0;
    for (int i = 0; i < D; i++) begin rob[i] = '0; ec[i] = '0; end
    commit_vld = 1'b0; commit_idx = '0; st_req_rdy = 1'b0; st_resp = 1'b0;

    #12;
    chk("rst_st_req_vld", 32'(st_req_vld), 0);
    chk("rst_st_req_idx", 32'(st_req_idx), 0);
    chk("rst_invld",      32'(invld), 0);
    chk("rst_cmpl",       32'({cmpl_vld, cmpl_rob, cmpl_exc, cmpl_ec}), 0);
    chk("rst_head",       32'(head), 0);

    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("empty_head",   32'(head), 0);
      chk("empty_st_req", 32'(st_req_vld), 0);
      chk("empty_invld",  32'(invld), 0);
    end

    // Loads walk the head from 0 up to 7
    do_load(0, 4'd5);
    for (int h = 1; h < 7; h++) do_load(h, RW'(h + 9));

    // Store at head 7: mismatched grant first, then matching grant
    step();
    vld[7] = 1'b1; ls[7] = 1'b1; succ[7] = 1'b1; exc[7] = 1'b0; rob[7] = 4'd9;
    commit_vld = 1'b1; commit_idx = 4'd8;
    @(negedge clk);
    chk("mismatch_invld", 32'(invld), 0);
    step();
    commit_idx = 4'd9;
    @(negedge clk);
    chk("mismatch_no_req", 32'(st_req_vld), 0);
    chk("grant_invld",     32'(invld), 0);
    step();
    commit_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      st_req_rdy = (k == 3);
      @(negedge clk);
      chk("st_req_held_vld", 32'(st_req_vld), 1);
      chk("st_req_held_idx", 32'(st_req_idx), 7);
      chk("st_req_invld",    32'(invld), 0);
    end
    step();
    st_req_rdy = 1'b0;
    @(negedge clk);
    chk("st_wait_no_req",   32'(st_req_vld), 0);
    chk("st_wait_no_invld", 32'(invld), 0);
    step();
    st_resp = 1'b1;
    @(negedge clk);
    chk("store_invld", 32'(invld), 32'h80);
    sb.push_back({4'd9, 1'b0, 4'h0});
    step();
    st_resp = 1'b0; vld[7] = 1'b0;
    @(negedge clk);
    chk("store_head_wrap", 32'(head), 0);
    chk("store_req_done",  32'(st_req_vld), 0);

    // Excepting store at head 0 retires without touching the D-cache
    step();
    vld[0] = 1'b1; ls[0] = 1'b1; succ[0] = 1'b0; exc[0] = 1'b1;
    ec[0] = 4'hD; rob[0] = 4'd3;
    @(negedge clk);
    chk("exc_invld",  32'(invld), 32'h01);
    chk("exc_no_req", 32'(st_req_vld), 0);
    sb.push_back({4'd3, 1'b1, 4'hD});
    step();
    vld[0] = 1'b0; exc[0] = 1'b0; ec[0] = 4'h0;
    @(negedge clk);
    chk("exc_no_req_after", 32'(st_req_vld), 0);
    chk("exc_head",         32'(head), 1);

    // Store at head 1 reaches ST_WAIT, then is flushed into DRAIN
    step();
    vld[1] = 1'b1; ls[1] = 1'b1; succ[1] = 1'b1; rob[1] = 4'd2;
    commit_vld = 1'b1; commit_idx = 4'd2;
    @(negedge clk);
    chk("fl_grant_invld", 32'(invld), 0);
    step();
    commit_vld = 1'b0; st_req_rdy = 1'b1;
    @(negedge clk);
    chk("fl_req_vld", 32'(st_req_vld), 1);
    chk("fl_req_idx", 32'(st_req_idx), 1);
    step();
    st_req_rdy = 1'b0;
    @(negedge clk);
    chk("fl_wait_no_req", 32'(st_req_vld), 0);
    step();
    flush = 1'b1; vld = '0;
    @(negedge clk);
    chk("fl_cycle_invld", 32'(invld), 0);
    step();
    flush = 1'b0;
    vld[0] = 1'b1; ls[0] = 1'b0; succ[0] = 1'b1; rob[0] = 4'd6;
    @(negedge clk);
    chk("drain_head",   32'(head), 0);
    chk("drain_invld",  32'(invld), 0);
    chk("drain_no_req", 32'(st_req_vld), 0);
    step();
    @(negedge clk);
    chk("drain_invld2", 32'(invld), 0);
    step();
    st_resp = 1'b1;
    @(negedge clk);
    chk("drain_resp_invld", 32'(invld), 0);
    step();
    st_resp = 1'b0;
    @(negedge clk);
    chk("post_drain_invld", 32'(invld), 32'h01);
    sb.push_back({4'd6, 1'b0, 4'h0});
    step();
    vld[0] = 1'b0;
    @(negedge clk);
    chk("post_drain_head", 32'(head), 1);

    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
